// File: rtl/matvec_pkg.sv
// Shared types and constants for the matvec8 input interface: word format,
// source FSM states and the throttle LFSR.
package matvec_pkg;

  localparam int K      = 8;
  localparam int DATA_W = 14;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shift Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic                     new_matrix;
    logic signed [DATA_W-1:0] data;
  } word_t;

  typedef enum logic [1:0] {IDLE, MAT, VEC, DRAIN} src_state_e;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {1'b0, s[15:1]} ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready skid buffer for word_t. The output register holds
// while stalled; a second register absorbs the word already in flight.
module stream_skid_buf
  import matvec_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  i_valid,
  input  word_t i_word,
  output logic  o_in_ready,
  output logic  o_valid,
  output word_t o_word,
  input  logic  i_ready
);

  logic  r_out_vld;
  logic  r_skid_vld;
  word_t r_out_word;
  word_t r_skid_word;
  logic  w_push;
  logic  w_out_free;

  assign o_in_ready = !r_skid_vld;
  assign w_push     = i_valid && !r_skid_vld;
  assign w_out_free = !r_out_vld || i_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_vld   <= 1'b0;
      r_skid_vld  <= 1'b0;
      r_out_word  <= '0;
      r_skid_word <= '0;
    end else if (w_out_free) begin
      if (r_skid_vld) begin
        r_out_word <= r_skid_word;
        r_out_vld  <= 1'b1;
        r_skid_vld <= 1'b0;
      end else begin
        r_out_vld <= w_push;
        if (w_push) r_out_word <= i_word;
      end
    end else if (w_push) begin
      r_skid_word <= i_word;
      r_skid_vld  <= 1'b1;
    end
  end

  assign o_valid = r_out_vld;
  assign o_word  = r_out_word;

endmodule

// File: rtl/matvec_stream_src.sv
// Streams matrix/vector frames from a local RAM into a matvec8 engine input,
// with optional LFSR throttling and a cycles-per-run counter.
module matvec_stream_src
  import matvec_pkg::*;
#(
  parameter int MEM_DEPTH = 1024,
  parameter int CNT_W     = 16,
  localparam int AW       = $clog2(MEM_DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load_en,
  input  logic [AW-1:0]            load_addr,
  input  logic [DATA_W-1:0]        load_data,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_vectors,
  input  logic [CNT_W-1:0]         reload_every,
  input  logic                     throttle_en,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_new_matrix,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              cycles
);

  localparam int MAT_WORDS = K * K;
  localparam int IDX_W     = $clog2(MAT_WORDS);
  localparam logic [IDX_W-1:0] MAT_LAST = IDX_W'(MAT_WORDS - 1);
  localparam logic [IDX_W-1:0] VEC_LAST = IDX_W'(K - 1);

  src_state_e r_state, w_state_nxt;
  logic [IDX_W-1:0]  r_idx, w_idx;
  logic [AW-1:0]     r_rd_addr, w_rd_addr;
  logic [CNT_W-1:0]  r_vec_cnt, r_rel_cnt, r_num_vec, r_reload;
  logic [CNT_W-1:0]  w_vec_next, w_rel_next;
  logic              r_busy, r_done, r_rd_vld, r_rd_nm;
  logic [31:0]       r_cycles;
  logic [15:0]       r_lfsr;
  logic [DATA_W-1:0] mem [MEM_DEPTH];
  logic [DATA_W-1:0] r_rd_data;

  logic  w_start_any, w_start_run, w_pop, w_room, w_throttle_ok, w_reload_hit;
  logic  w_mat_phase, w_fetch, w_frame_end, w_word_nm, w_finish;
  logic  w_out_valid, w_skid_in_ready;
  logic [1:0] w_occ;
  word_t w_rd_word, w_out_word;

  assign w_start_any   = (r_state == IDLE) && start;
  assign w_start_run   = w_start_any && (num_vectors != '0);
  assign w_pop         = w_out_valid && out_ready;
  assign w_throttle_ok = !throttle_en || r_lfsr[0];
  assign w_vec_next    = r_vec_cnt + CNT_W'(1);
  assign w_rel_next    = r_rel_cnt + CNT_W'(1);
  assign w_reload_hit  = (r_reload != '0) && (w_rel_next == r_reload);

  // Words held or in flight; a fetch is allowed only if it can never overflow the skid buffer.
  assign w_occ  = 2'(w_out_valid) + 2'(!w_skid_in_ready) + 2'(r_rd_vld);
  assign w_room = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns the next state and no latch is inferred.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  if (w_start_run) w_state_nxt = (w_fetch && w_frame_end) ? VEC : MAT;
      MAT:   if (w_fetch && w_frame_end) w_state_nxt = VEC;
      VEC:   if (w_fetch && w_frame_end) begin
               if (w_vec_next == r_num_vec) w_state_nxt = DRAIN;
               else if (w_reload_hit)       w_state_nxt = MAT;
             end
      DRAIN: if (w_finish) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // The start cycle itself fetches matrix word 0 so the first word appears two edges later.
  always_comb begin
    w_mat_phase = (r_state == MAT) || w_start_run;
    w_idx       = w_start_run ? '0 : r_idx;
    w_rd_addr   = w_start_run ? '0 : r_rd_addr;
    w_fetch     = (w_start_run || (r_state == MAT) || (r_state == VEC)) && w_room && w_throttle_ok;
    w_frame_end = w_mat_phase ? (w_idx == MAT_LAST) : (w_idx == VEC_LAST);
    w_word_nm   = w_mat_phase && (w_idx == '0);
    w_finish    = ((r_state == DRAIN) && w_pop && w_skid_in_ready && !r_rd_vld) ||
                  (w_start_any && (num_vectors == '0));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx     <= '0;
      r_rd_addr <= '0;
      r_vec_cnt <= '0;
      r_rel_cnt <= '0;
      r_num_vec <= '0;
      r_reload  <= '0;
    end else begin
      if (w_start_run) begin
        r_num_vec <= num_vectors;
        r_reload  <= reload_every;
        r_vec_cnt <= '0;
        r_rel_cnt <= '0;
        r_idx     <= '0;
        r_rd_addr <= '0;
      end
      if (w_fetch) begin
        r_rd_addr <= w_rd_addr + AW'(1);
        r_idx     <= w_frame_end ? '0 : w_idx + IDX_W'(1);
        if ((r_state == VEC) && w_frame_end) begin
          r_vec_cnt <= w_vec_next;
          r_rel_cnt <= w_reload_hit ? '0 : w_rel_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_cycles <= '0;
      r_lfsr   <= LFSR_SEED;
      r_rd_vld <= 1'b0;
    end else begin
      r_done   <= w_finish;
      r_rd_vld <= w_fetch;
      if (w_start_run)   r_busy <= 1'b1;
      else if (w_finish) r_busy <= 1'b0;
      if (w_start_any)   r_cycles <= '0;
      else if (r_busy)   r_cycles <= r_cycles + 32'd1;
      if (r_busy)        r_lfsr <= lfsr_step(r_lfsr);
    end
  end

  // NOTE: RAM and its read register carry no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (load_en && !r_busy) mem[load_addr] <= load_data;
    if (w_fetch) begin
      r_rd_data <= mem[w_rd_addr];
      r_rd_nm   <= w_word_nm;
    end
  end

  assign w_rd_word = word_t'{new_matrix: r_rd_nm, data: r_rd_data};

  stream_skid_buf u_skid (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_valid    (r_rd_vld),
    .i_word     (w_rd_word),
    .o_in_ready (w_skid_in_ready),
    .o_valid    (w_out_valid),
    .o_word     (w_out_word),
    .i_ready    (out_ready)
  );

  assign out_valid      = w_out_valid;
  assign out_data       = w_out_word.data;
  assign out_new_matrix = w_out_word.new_matrix;
  assign busy           = r_busy;
  assign done           = r_done;
  assign cycles         = r_cycles;

endmodule

// File: tb/tb_matvec_stream_src.sv
// Scoreboard bench for matvec_stream_src: expected word streams are derived
// from frame rules and a RAM image; a negedge monitor pops and compares.
module tb_matvec_stream_src;
  import matvec_pkg::*;

  localparam int MEM_DEPTH = 1024;
  localparam int CNT_W     = 16;
  localparam int AW        = 10;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic                     load_en = 1'b0;
  logic [AW-1:0]            load_addr = '0;
  logic [DATA_W-1:0]        load_data = '0;
  logic                     start = 1'b0;
  logic [CNT_W-1:0]         num_vectors = '0;
  logic [CNT_W-1:0]         reload_every = '0;
  logic                     throttle_en = 1'b0;
  logic                     out_valid;
  logic                     out_ready = 1'b1;
  logic signed [DATA_W-1:0] out_data;
  logic                     out_new_matrix;
  logic                     busy;
  logic                     done;
  logic [31:0]              cycles;

  matvec_stream_src #(.MEM_DEPTH(MEM_DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .num_vectors(num_vectors),
    .reload_every(reload_every), .throttle_en(throttle_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_new_matrix(out_new_matrix),
    .busy(busy), .done(done), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct { bit nm; int data; } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   tb_mem [MEM_DEPTH];

  int checks = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name, input longint act, input longint req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor state
  int   cyc = 0, start_cyc = 0, first_valid_cyc = -1, last_xfer_cyc = -1, done_cyc = -1;
  int   xfer_cnt = 0, valid_cnt = 0;
  bit   done_seen = 0, prev_hold = 0, prev_done = 0;
  logic signed [DATA_W-1:0] prev_data = '0;
  logic prev_nm = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      prev_hold = 0;
      prev_done = 0;
    end else begin
      if (start && !busy) begin
        start_cyc = cyc;
        first_valid_cyc = -1;
      end
      if (prev_hold)
        check(out_valid && (out_data == prev_data) && (out_new_matrix == prev_nm),
              "hold_stable", {out_valid, out_new_matrix, out_data}, {1'b1, prev_nm, prev_data});
      if (out_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check(0, "extra_word", out_data, 0);
        else begin
          e = exp_q.pop_front();
          check(int'(out_data) == e.data, $sformatf("word_data#%0d", xfer_cnt), out_data, e.data);
          check(out_new_matrix == e.nm, $sformatf("word_new_matrix#%0d", xfer_cnt), out_new_matrix, e.nm);
        end
        xfer_cnt++;
        last_xfer_cyc = cyc;
      end
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      prev_nm   = out_new_matrix;
      if (done) begin
        check(!prev_done, "done_pulse_width", 1, 0);
        done_seen = 1;
        done_cyc  = cyc;
      end
      prev_done = done;
    end
  end

  // Ready pattern driver: 0 = always ready, 1 = 1,0,0,1 repeating, 2 = random
  int rmode = 0;
  int rphase = 0;
  initial forever begin
    @(posedge clk); #1;
    case (rmode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((rphase % 4) == 0) || ((rphase % 4) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    rphase++;
  end

  task automatic run_case(input string tag, input int nv, input int rel, input int rmode_i,
                          input bit thr, input int abort_after, input int poke_at);
    int addr;
    int exp_words;
    addr = 0;
    exp_q.delete();
    for (int v = 0; v < nv; v++) begin
      if (v == 0 || (rel != 0 && (v % rel) == 0))
        for (int i = 0; i < K * K; i++) begin
          exp_q.push_back('{nm: (i == 0), data: tb_mem[addr]});
          addr = (addr + 1) % MEM_DEPTH;
        end
      for (int i = 0; i < K; i++) begin
        exp_q.push_back('{nm: 1'b0, data: tb_mem[addr]});
        addr = (addr + 1) % MEM_DEPTH;
      end
    end
    exp_words = exp_q.size();
    xfer_cnt = 0; valid_cnt = 0; done_seen = 0; first_valid_cyc = -1; last_xfer_cyc = -1;
    rmode = rmode_i; rphase = 0;
    @(posedge clk); #1;
    start = 1'b1; num_vectors = CNT_W'(nv); reload_every = CNT_W'(rel); throttle_en = thr;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 20000 && !done_seen; k++) begin
      if (poke_at > 0) begin
        if (k == poke_at) begin
          start = 1'b1; num_vectors = 16'd2; load_en = 1'b1; load_addr = 10'd70; load_data = 14'h1555;
        end else begin
          start = 1'b0; load_en = 1'b0;
        end
      end
      if (abort_after > 0 && xfer_cnt > abort_after) begin
        reset_n = 1'b0; #1;
        check(out_valid == 1'b0, {tag, "_rst_valid"}, out_valid, 0);
        check(out_data == '0, {tag, "_rst_data"}, out_data, 0);
        check(out_new_matrix == 1'b0, {tag, "_rst_nm"}, out_new_matrix, 0);
        check(busy == 1'b0, {tag, "_rst_busy"}, busy, 0);
        check(done == 1'b0, {tag, "_rst_done"}, done, 0);
        check(cycles == 32'd0, {tag, "_rst_cycles"}, cycles, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; load_en = 1'b0;
    check(done_seen, {tag, "_timeout"}, done_seen, 1);
    check(exp_q.size() == 0, {tag, "_missing_words"}, exp_q.size(), 0);
    check(xfer_cnt == exp_words, {tag, "_word_count"}, xfer_cnt, exp_words);
    check(busy == 1'b0, {tag, "_busy_after"}, busy, 0);
    if (nv == 0) begin
      check(done_cyc == start_cyc + 1, {tag, "_done_latency"}, done_cyc - start_cyc, 1);
      check(valid_cnt == 0, {tag, "_no_valids"}, valid_cnt, 0);
      check(cycles == 32'd0, {tag, "_cycles"}, cycles, 0);
    end else begin
      check(done_cyc == last_xfer_cyc + 1, {tag, "_done_after_last"}, done_cyc - last_xfer_cyc, 1);
      if (!thr)
        check(first_valid_cyc == start_cyc + 2, {tag, "_first_valid"}, first_valid_cyc - start_cyc, 2);
      if (!thr && rmode_i == 0)
        check(cycles == 32'(exp_words + 1), {tag, "_cycles"}, cycles, exp_words + 1);
      else if (thr && rmode_i == 0)
        check(cycles > 32'(exp_words + 1), {tag, "_cycles_gt"}, cycles, exp_words + 2);
      else
        check(cycles >= 32'(exp_words + 1), {tag, "_cycles_ge"}, cycles, exp_words + 1);
    end
  endtask

  initial begin
    logic signed [DATA_W-1:0] d;
    int a;
    repeat (3) @(posedge clk);
    #1;
    check(out_valid == 1'b0, "reset_valid", out_valid, 0);
    check(out_data == '0, "reset_data", out_data, 0);
    check(busy == 1'b0, "reset_busy", busy, 0);
    check(done == 1'b0, "reset_done", done, 0);
    check(cycles == 32'd0, "reset_cycles", cycles, 0);
    reset_n = 1'b1;

    for (int i = 0; i < MEM_DEPTH; i++) begin
      @(posedge clk); #1;
      load_en = 1'b1; load_addr = AW'(i); load_data = DATA_W'(i - 512);
      tb_mem[i] = i - 512;
    end
    @(posedge clk); #1;
    load_en = 1'b0;

    run_case("t1_basic",    1, 0, 0, 0, 0,  0);
    run_case("t2_reload",   3, 2, 0, 0, 0,  0);
    run_case("t3_ready",    1, 0, 1, 0, 0,  0);
    run_case("t4_throttle", 1, 0, 0, 1, 0,  0);
    run_case("t5_abort",    1, 0, 0, 0, 30, 0);
    run_case("t5_restart",  1, 0, 0, 0, 0,  0);
    run_case("t6_zero",     0, 0, 0, 0, 0,  0);
    run_case("t6_poke",     1, 0, 0, 0, 0,  20);
    run_case("wrap",       15, 1, 0, 0, 0,  0);

    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      a = int'($urandom_range(0, 299));
      d = DATA_W'($urandom);
      load_en = 1'b1; load_addr = AW'(a); load_data = d;
      tb_mem[a] = int'(d);
    end
    @(posedge clk); #1;
    load_en = 1'b0;

    for (int r = 0; r < 4; r++)
      run_case($sformatf("rand%0d", r), int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
               2, 1'($urandom_range(0, 1)), 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
